// File: rtl/multiplier_4x4_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
interface multiplier_4x4_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   y;
  logic                 busy;
  logic                 done;

  // Requester side: launches multiplies and observes results.
  modport master (
    output start, a, b,
    input  y, busy, done
  );

  // Multiplier side.
  modport slave (
    input  start, a, b,
    output y, busy, done
  );
endinterface

// File: rtl/multiplier_4x4.sv
// Unsigned WIDTH x WIDTH shift-add multiplier; one partial product per cycle,
// result held in y until the next multiply completes.
module multiplier_4x4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  multiplier_4x4_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   y_q, y_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   sum;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath update; the final add is folded into the y load.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = PW'(bus.a);
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          y_d     = sum;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_multiplier_4x4.sv
// Scoreboard bench for multiplier_4x4: stimulus queues expected products and
// launch cycles, a negedge monitor checks every done pulse and y stability.
module tb_multiplier_4x4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  int   exp_y_q[$];
  int   exp_launch_q[$];
  logic [7:0] prev_y;

  multiplier_4x4_if #(.WIDTH(4)) bus ();

  multiplier_4x4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: compares results on done and watches y between completions.
  initial begin
    int exp_y;
    int launch;
    prev_y = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1) begin
        if (exp_y_q.size() == 0) begin
          check("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          exp_y  = exp_y_q.pop_front();
          launch = exp_launch_q.pop_front();
          check("product", 32'(bus.y), 32'(exp_y));
          check("latency", 32'(cyc - launch), 32'd4);
        end
      end else if (rst_n === 1'b1) begin
        check("y_hold", 32'(bus.y), 32'(prev_y));
      end
      prev_y = bus.y;
    end
  end

  // Pulse start for one cycle and queue the expected product.
  task automatic issue(input int av, input int bv, input int exp);
    bus.a     = 4'(av);
    bus.b     = 4'(bv);
    bus.start = 1'b1;
    exp_y_q.push_back(exp);
    exp_launch_q.push_back(cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 4'(av ^ 4'hA);
    bus.b     = 4'(bv ^ 4'h5);
  endtask

  // Wait (bounded) until the DUT is idle and the scoreboard has drained.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (bus.busy === 1'b0 && exp_y_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("timeout_pending", 32'(exp_y_q.size()), 32'd0);
      exp_y_q.delete();
      exp_launch_q.delete();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 4'd5;
    bus.b     = 4'd5;

    // Reset held with start high.
    repeat (3) @(negedge clk);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", 32'(bus.busy), 32'd0);

    // First vector, then back-to-back restart in its done cycle.
    issue(2, 11, 22);
    wait_idle();
    issue(3, 4, 12);
    @(negedge clk);
    check("y_held_22", 32'(bus.y), 32'd22);
    wait_idle();

    // Directed vectors and corners.
    issue(14, 6, 84);  wait_idle();
    issue(12, 3, 36);  wait_idle();
    issue(9, 5, 45);   wait_idle();
    issue(15, 15, 225); wait_idle();
    issue(0, 13, 0);   wait_idle();
    issue(7, 0, 0);    wait_idle();

    // Start while busy with new operands is ignored.
    issue(6, 7, 42);
    bus.a     = 4'd15;
    bus.b     = 4'd15;
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    check("busy_during_ignore", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);

    // Reset two cycles into a multiply aborts it with no done.
    bus.a     = 4'd9;
    bus.b     = 4'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_y", 32'(bus.y), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_idle", 32'(bus.busy), 32'd0);

    // Normal operation after the abort.
    issue(13, 11, 143);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
